// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Multi-cycle controller for the ALU_8 datapath. Accepts one
//            instruction at a time, reads operands from a 4 x 8-bit register
//            file, holds them on the ALU for SETTLE_CYCLES, then writes back
//            the result and the Z/N/V flags and returns a response.
//            Optional macro ALU_SEQ_STATS_EN adds the stat_ops/stat_ovf
//            counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic       instr_ld,
   input  logic [3:0] instr_op,
   input  logic [1:0] instr_rd,
   input  logic [1:0] instr_ra,
   input  logic [1:0] instr_rb,
   input  logic [7:0] instr_imm,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   input  logic [7:0] alu_result,
   input  logic       alu_overflow,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [2:0] rsp_flags
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [15:0] stat_ops,
   output logic [7:0]  stat_ovf
`endif
);

   // Settle time must fit the 4-bit counter and be at least one cycle.
   generate
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range_err
         $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] SETTLE_W = SETTLE_CYCLES[3:0];

   typedef enum logic [2:0] {
      RST_WAIT = 3'd0,
      IDLE     = 3'd1,
      ISSUE    = 3'd2,
      CAPTURE  = 3'd3,
      RESP     = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [1:0]      rd_q, rd_d;
   logic            ld_q, ld_d;
   logic [7:0]      alu_a_q, alu_a_d;
   logic [7:0]      alu_b_q, alu_b_d;
   logic [3:0]      alu_op_q, alu_op_d;
   logic [3:0][7:0] regs_q, regs_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic [2:0]      flags_q, flags_d;

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      ld_d        = ld_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      regs_d      = regs_q;
      rsp_data_d  = rsp_data_q;
      flags_d     = flags_q;
      instr_ready = 1'b0;
      rsp_valid   = 1'b0;
      case (state_q)
         RST_WAIT: state_d = IDLE;
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               rd_d = instr_rd;
               ld_d = instr_ld;
               if (instr_ld) begin
                  // Immediate load completes on the accept edge; ALU untouched.
                  regs_d[instr_rd] = instr_imm;
                  rsp_data_d       = instr_imm;
                  state_d          = RESP;
               end else begin
                  // Operands are read here, so aliasing rd with ra/rb is safe.
                  alu_a_d  = regs_q[instr_ra];
                  alu_b_d  = regs_q[instr_rb];
                  alu_op_d = instr_op;
                  cnt_d    = 4'd1;
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (cnt_q == SETTLE_W) begin
               regs_d[rd_q] = alu_result;
               rsp_data_d   = alu_result;
               flags_d      = {(alu_result == 8'h00), alu_result[7], alu_overflow};
               state_d      = CAPTURE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         CAPTURE: state_d = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = RST_WAIT;
      endcase
   end

   // State and datapath registers; reset drops any in-flight work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RST_WAIT;
         cnt_q      <= 4'd0;
         rd_q       <= 2'd0;
         ld_q       <= 1'b0;
         alu_a_q    <= 8'h00;
         alu_b_q    <= 8'h00;
         alu_op_q   <= 4'h0;
         regs_q     <= '0;
         rsp_data_q <= 8'h00;
         flags_q    <= 3'b000;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         ld_q       <= ld_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         regs_q     <= regs_d;
         rsp_data_q <= rsp_data_d;
         flags_q    <= flags_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flags = flags_q;

`ifdef ALU_SEQ_STATS_EN
   logic [15:0] stat_ops_q;
   logic [7:0]  stat_ovf_q;

   // Saturating counters of completed responses and overflowing ALU ops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops_q <= 16'h0000;
         stat_ovf_q <= 8'h00;
      end else if (state_q == RESP && rsp_ready) begin
         if (stat_ops_q != 16'hFFFF) begin
            stat_ops_q <= stat_ops_q + 16'd1;
         end
         if (!ld_q && flags_q[0] && stat_ovf_q != 8'hFF) begin
            stat_ovf_q <= stat_ovf_q + 8'd1;
         end
      end
   end

   assign stat_ops = stat_ops_q;
   assign stat_ovf = stat_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Self-checking bench for alu_op_sequencer with an adder ALU stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

   localparam int SETTLE = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic       instr_ld = 1'b0;
   logic [3:0] instr_op = 4'h0;
   logic [1:0] instr_rd = 2'd0;
   logic [1:0] instr_ra = 2'd0;
   logic [1:0] instr_rb = 2'd0;
   logic [7:0] instr_imm = 8'h00;
   logic [7:0] alu_a, alu_b;
   logic [3:0] alu_op;
   logic [7:0] alu_result;
   logic       alu_overflow;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic [2:0] rsp_flags;
`ifdef ALU_SEQ_STATS_EN
   logic [15:0] stat_ops;
   logic [7:0]  stat_ovf;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // ALU stub: adder with carry-out as overflow.
   assign {alu_overflow, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

   alu_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_ld(instr_ld), .instr_op(instr_op), .instr_rd(instr_rd),
      .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_imm(instr_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags)
`ifdef ALU_SEQ_STATS_EN
      , .stat_ops(stat_ops), .stat_ovf(stat_ovf)
`endif
   );

   task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Asserts reset asynchronously, checks reset values and the RST_WAIT cycle.
   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      instr_valid = 1'b0;
      rsp_ready = 1'b0;
      #1;
      ck("rst_rsp_valid_async", rsp_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      ck("rst_instr_ready", instr_ready, 0);
      ck("rst_outputs", {alu_a, alu_b, alu_op, rsp_data, rsp_flags, rsp_valid}, 0);
      rst_n = 1'b1;
      #1;
      ck("rst_wait_ready", instr_ready, 0);
      @(posedge clk);
      #1;
      ck("idle_ready", instr_ready, 1);
   endtask

   // Issues one instruction, scrambles inputs after accept, measures latency
   // (rsp_valid high in cycle N after the accept edge) and completes the handshake.
   task automatic run_instr(input logic ld, input logic [3:0] op, input logic [1:0] rd,
                            input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm,
                            output logic [7:0] data, output logic [2:0] flags, output int lat);
      int guard = 0;
      while (!instr_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      if (!instr_ready) ck("accept_timeout", instr_ready, 1);
      instr_valid = 1'b1;
      instr_ld = ld; instr_op = op; instr_rd = rd;
      instr_ra = ra; instr_rb = rb; instr_imm = imm;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr_ld  = 1'($urandom);  instr_op = 4'($urandom); instr_rd = 2'($urandom);
      instr_ra  = 2'($urandom);  instr_rb = 2'($urandom); instr_imm = 8'($urandom);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      data  = rsp_data;
      flags = rsp_flags;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      ck("post_hs_valid", rsp_valid, 0);
      ck("post_hs_ready", instr_ready, 1);
   endtask

   typedef struct {
      logic       ld;
      logic [3:0] op;
      logic [1:0] rd, ra, rb;
      logic [7:0] imm;
      logic [7:0] exp_data;
      logic [2:0] exp_flags;
      int         exp_lat;
      logic [3:0] exp_op;
   } vec_t;

   vec_t vecs[8];

   logic [7:0] m_regs[4];
   logic [2:0] m_flags;
   logic [7:0] m_a, m_b;
   logic [3:0] m_op;

   initial begin
      logic [7:0] d;
      logic [2:0] f;
      int         lat;

      vecs[0] = '{1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 8'h7F, 8'h7F, 3'b000, 1, 4'h0};
      vecs[1] = '{1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 8'h01, 8'h01, 3'b000, 1, 4'h0};
      vecs[2] = '{1'b0, 4'h0, 2'd2, 2'd0, 2'd1, 8'h00, 8'h80, 3'b010, SETTLE + 2, 4'h0};
      vecs[3] = '{1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 3'b010, 1, 4'h0};
      vecs[4] = '{1'b0, 4'h3, 2'd3, 2'd0, 2'd1, 8'h00, 8'h00, 3'b101, SETTLE + 2, 4'h3};
      vecs[5] = '{1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 8'h55, 8'h55, 3'b101, 1, 4'h3};
      vecs[6] = '{1'b0, 4'hA, 2'd1, 2'd1, 2'd1, 8'h00, 8'h02, 3'b000, SETTLE + 2, 4'hA};
      vecs[7] = '{1'b0, 4'h5, 2'd2, 2'd2, 2'd1, 8'h00, 8'h82, 3'b010, SETTLE + 2, 4'h5};

      do_reset();

      // Directed table: loads, ALU ops, overflow/zero, flag persistence, aliasing.
      for (int i = 0; i < 8; i++) begin
         run_instr(vecs[i].ld, vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb,
                   vecs[i].imm, d, f, lat);
         ck($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
         ck($sformatf("vec%0d_flags", i), f, vecs[i].exp_flags);
         ck($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         ck($sformatf("vec%0d_aluop", i), alu_op, vecs[i].exp_op);
      end

      // Response stall: R0=55 R1=02 R2=82 R3=00 here. LD R3=C3, stall 10 cycles
      // while the next instruction (ALU R0=R0+R3) is already offered.
      instr_valid = 1'b1; instr_ld = 1'b1; instr_rd = 2'd3; instr_imm = 8'hC3;
      @(posedge clk); #1;
      instr_ld = 1'b0; instr_op = 4'h7; instr_rd = 2'd0; instr_ra = 2'd0; instr_rb = 2'd3;
      for (int i = 0; i < 10; i++) begin
         ck("stall_valid", rsp_valid, 1);
         ck("stall_data", rsp_data, 8'hC3);
         ck("stall_ready", instr_ready, 0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      ck("stall_release_ready", instr_ready, 1);
      ck("stall_release_valid", rsp_valid, 0);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      ck("after_stall_lat", lat, SETTLE + 2);
      ck("after_stall_data", rsp_data, 8'h18);
      ck("after_stall_flags", rsp_flags, 3'b001);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Reset during ISSUE of an ALU op writing R2: no write-back, no response.
      instr_valid = 1'b1; instr_ld = 1'b0; instr_op = 4'h1;
      instr_rd = 2'd2; instr_ra = 2'd0; instr_rb = 2'd1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      ck("midop_in_issue", rsp_valid, 0);
      do_reset();
      run_instr(1'b0, 4'h2, 2'd3, 2'd2, 2'd2, 8'h00, d, f, lat);
      ck("midop_r2_cleared", d, 8'h00);
      ck("midop_flags", f, 3'b100);

`ifdef ALU_SEQ_STATS_EN
      do_reset();
      ck("stat_ops_reset", stat_ops, 0);
      ck("stat_ovf_reset", stat_ovf, 0);
      run_instr(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 8'hFF, d, f, lat);
      run_instr(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 8'h01, d, f, lat);
      run_instr(1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 8'h10, d, f, lat);
      run_instr(1'b0, 4'h0, 2'd3, 2'd0, 2'd1, 8'h00, d, f, lat);
      run_instr(1'b0, 4'h0, 2'd3, 2'd1, 2'd2, 8'h00, d, f, lat);
      ck("stat_ops", stat_ops, 5);
      ck("stat_ovf", stat_ovf, 1);
`endif

      // Randomized phase against a reference model of the register file and flags.
      do_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_flags = 3'b000; m_a = 8'h00; m_b = 8'h00; m_op = 4'h0;
      for (int n = 0; n < 60; n++) begin
         logic       ld;
         logic [3:0] op;
         logic [1:0] rd, ra, rb;
         logic [7:0] imm, e_data;
         int         sum, e_lat;
         ld  = 1'($urandom_range(0, 1));
         op  = 4'($urandom);
         rd  = 2'($urandom); ra = 2'($urandom); rb = 2'($urandom);
         imm = 8'($urandom);
         if (ld) begin
            e_data = imm;
            e_lat  = 1;
         end else begin
            m_a  = m_regs[ra];
            m_b  = m_regs[rb];
            m_op = op;
            sum  = int'(m_a) + int'(m_b);
            e_data  = 8'(sum % 256);
            m_flags = {e_data == 8'h00, e_data >= 8'h80, sum > 255};
            e_lat   = SETTLE + 2;
         end
         m_regs[rd] = e_data;
         run_instr(ld, op, rd, ra, rb, imm, d, f, lat);
         ck("rnd_data", d, e_data);
         ck("rnd_flags", f, m_flags);
         ck("rnd_lat", lat, e_lat);
         ck("rnd_alu_outs", {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
